// File: rtl/frame_pkg.sv
// Shared types and defaults for the parametrised preamble/OFDM frame assembler.
// Optional inter-frame gap is enabled with the FRAME_GAP_EN macro.
package frame_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PREAMB = 2'd1,
      ST_DATA   = 2'd2,
      ST_GAP    = 2'd3
   } state_t;

   localparam int DEF_DW         = 16;
   localparam int DEF_PREAMB_LEN = 320;
   localparam int DEF_SYM_LEN    = 80;

   // Counter width for a length; never narrower than one bit.
   function automatic int cnt_w(input int len);
      return (len < 2) ? 1 : $clog2(len);
   endfunction

endpackage

// File: rtl/frame_slot_counter.sv
// Sample-in-slot and symbol-in-frame counters for the frame assembler.
// Behaviour does not depend on FRAME_GAP_EN; the top selects the wrap point per state.
module frame_slot_counter
   import frame_pkg::*;
#(
   parameter int SW     = 9,
   parameter int NSYM_W = 8
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_adv,
   input  logic              i_load,
   input  logic [SW-1:0]     i_load_val,
   input  logic              i_inc,
   input  logic [SW-1:0]     i_wrap_val,
   input  logic              i_sym_inc,
   input  logic [NSYM_W-1:0] i_sym_last,
   output logic [SW-1:0]     o_samp_cnt,
   output logic              o_last_samp,
   output logic              o_last_sym
);

   logic [SW-1:0]     r_samp;
   logic [NSYM_W-1:0] r_sym;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_samp <= '0;
         r_sym  <= '0;
      end else if (i_adv) begin
         if (i_load) begin
            r_samp <= i_load_val;
            r_sym  <= '0;
         end else if (i_inc) begin
            if (o_last_samp) begin
               r_samp <= '0;
               if (i_sym_inc)
                  r_sym <= r_sym + 1'b1;
            end else begin
               r_samp <= r_samp + 1'b1;
            end
         end
      end
   end

   assign o_samp_cnt  = r_samp;
   assign o_last_samp = (r_samp == i_wrap_val);
   assign o_last_sym  = (r_sym == i_sym_last);

endmodule

// File: rtl/frame_assembler_param.sv
// Streams PREAMB_LEN preamble samples then n_syms OFDM symbols per frame, one per adv.
// Define FRAME_GAP_EN to append GAP_LEN zero samples after each frame.
//
//  state     | meaning
//  ST_IDLE   | waiting for adv with nonzero n_syms; emits zeros otherwise
//  ST_PREAMB | pulling preamble samples 1..PREAMB_LEN-1
//  ST_DATA   | pulling OFDM samples, sym_cnt counts symbols
//  ST_GAP    | emitting GAP_LEN zero samples (FRAME_GAP_EN only)
module frame_assembler_param
   import frame_pkg::*;
#(
   parameter int DW         = DEF_DW,
   parameter int PREAMB_LEN = DEF_PREAMB_LEN,
   parameter int SYM_LEN    = DEF_SYM_LEN,
   parameter int NSYM_W     = 8,
   parameter int GAP_LEN    = 16
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_enable,
   input  logic                 i_ready_in,
   input  logic [NSYM_W-1:0]    i_n_syms,
   input  logic signed [DW-1:0] i_pre_i,
   input  logic signed [DW-1:0] i_pre_q,
   output logic                 o_pre_req,
   input  logic signed [DW-1:0] i_ofdm_i,
   input  logic signed [DW-1:0] i_ofdm_q,
   output logic                 o_ofdm_req,
   output logic signed [DW-1:0] o_i,
   output logic signed [DW-1:0] o_q,
   output logic                 o_sop,
   output logic                 o_eop,
   output logic                 o_sos,
   output logic                 o_busy
);

   localparam int MAX_PS  = (PREAMB_LEN > SYM_LEN) ? PREAMB_LEN : SYM_LEN;
   localparam int MAX_LEN = (MAX_PS > GAP_LEN) ? MAX_PS : GAP_LEN;
   localparam int SW      = cnt_w(MAX_LEN);

   localparam logic [SW-1:0] PRE_LAST = SW'(PREAMB_LEN - 1);
   localparam logic [SW-1:0] SYM_LAST = SW'(SYM_LEN - 1);
   localparam logic [SW-1:0] GAP_LAST = SW'(GAP_LEN - 1);

   state_t               r_state, w_next;
   logic [NSYM_W-1:0]    r_nsym_lat;
   logic signed [DW-1:0] r_i, r_q;
   logic                 r_sop, r_eop, r_sos, r_busy;

   logic                 w_adv;
   logic                 w_load, w_inc, w_sym_inc, w_nsym_ld;
   logic [SW-1:0]        w_wrap_val;
   logic [SW-1:0]        w_samp_cnt;
   logic                 w_last_samp, w_last_sym;
   logic signed [DW-1:0] w_smp_i, w_smp_q;
   logic                 w_sop, w_eop, w_sos;

   assign w_adv = i_enable & i_ready_in;

   frame_slot_counter #(
      .SW     (SW),
      .NSYM_W (NSYM_W)
   ) u_slot_cnt (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_adv       (w_adv),
      .i_load      (w_load),
      .i_load_val  (SW'(1)),
      .i_inc       (w_inc),
      .i_wrap_val  (w_wrap_val),
      .i_sym_inc   (w_sym_inc),
      .i_sym_last  (r_nsym_lat - 1'b1),
      .o_samp_cnt  (w_samp_cnt),
      .o_last_samp (w_last_samp),
      .o_last_sym  (w_last_sym)
   );

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      o_pre_req  = 1'b0;
      o_ofdm_req = 1'b0;
      w_load     = 1'b0;
      w_inc      = 1'b0;
      w_sym_inc  = 1'b0;
      w_nsym_ld  = 1'b0;
      w_wrap_val = PRE_LAST;
      w_smp_i    = '0;
      w_smp_q    = '0;
      w_sop      = 1'b0;
      w_eop      = 1'b0;
      w_sos      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Preamble sample 0 is taken here so back-to-back frames have no bubble.
            if (w_adv && (i_n_syms != '0)) begin
               w_nsym_ld = 1'b1;
               o_pre_req = 1'b1;
               w_smp_i   = i_pre_i;
               w_smp_q   = i_pre_q;
               w_sop     = 1'b1;
               w_load    = 1'b1;
               w_next    = ST_PREAMB;
            end
         end
         ST_PREAMB: begin
            w_wrap_val = PRE_LAST;
            if (w_adv) begin
               o_pre_req = 1'b1;
               w_smp_i   = i_pre_i;
               w_smp_q   = i_pre_q;
               w_inc     = 1'b1;
               if (w_last_samp)
                  w_next = ST_DATA;
            end
         end
         ST_DATA: begin
            w_wrap_val = SYM_LAST;
            if (w_adv) begin
               o_ofdm_req = 1'b1;
               w_smp_i    = i_ofdm_i;
               w_smp_q    = i_ofdm_q;
               w_inc      = 1'b1;
               w_sym_inc  = 1'b1;
               w_sos      = (w_samp_cnt == '0);
               if (w_last_samp && w_last_sym) begin
                  w_eop = 1'b1;
`ifdef FRAME_GAP_EN
                  w_next = ST_GAP;
`else
                  w_next = ST_IDLE;
`endif
               end
            end
         end
         ST_GAP: begin
            w_wrap_val = GAP_LAST;
`ifdef FRAME_GAP_EN
            if (w_adv) begin
               w_inc = 1'b1;
               if (w_last_samp)
                  w_next = ST_IDLE;
            end
`else
            w_next = ST_IDLE;
`endif
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Disabled: everything frozen. Enabled without a request: I/Q hold, markers drop.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_nsym_lat <= '0;
         r_i        <= '0;
         r_q        <= '0;
         r_sop      <= 1'b0;
         r_eop      <= 1'b0;
         r_sos      <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_busy <= (w_next != ST_IDLE);
         if (w_nsym_ld)
            r_nsym_lat <= i_n_syms;
         if (w_adv) begin
            r_i   <= w_smp_i;
            r_q   <= w_smp_q;
            r_sop <= w_sop;
            r_eop <= w_eop;
            r_sos <= w_sos;
         end else if (i_enable) begin
            r_sop <= 1'b0;
            r_eop <= 1'b0;
            r_sos <= 1'b0;
         end
      end
   end

   assign o_i    = r_i;
   assign o_q    = r_q;
   assign o_sop  = r_sop;
   assign o_eop  = r_eop;
   assign o_sos  = r_sos;
   assign o_busy = r_busy;

endmodule

// File: tb/tb_frame_assembler_param.sv
// Scoreboard bench for frame_assembler_param with PREAMB_LEN=4, SYM_LEN=3, GAP_LEN=2.
// Build with FRAME_GAP_EN defined to also cover the inter-frame gap.
module tb_frame_assembler_param;

   localparam int PL = 4;
   localparam int SL = 3;
   localparam int GL = 2;

   typedef struct {
      logic [15:0] i;
      logic [15:0] q;
      logic        sop;
      logic        eop;
      logic        sos;
      logic        busy;
      logic [1:0]  src;
   } ent_t;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        ready;
   logic [7:0]  n_syms;
   logic [15:0] pre_i, pre_q, ofdm_i, ofdm_q;
   logic        pre_req, ofdm_req;
   logic [15:0] o_i, o_q;
   logic        sop, eop, sos, busy;

   int   pre_idx;
   int   ofdm_idx;
   int   exp_ofdm;
   int   n_vec;
   int   n_err;
   ent_t exp_q[$];
   ent_t last;

   assign pre_i  = 16'(10 + (pre_idx % PL));
   assign pre_q  = 16'(-(10 + (pre_idx % PL)));
   assign ofdm_i = 16'(20 + ofdm_idx);
   assign ofdm_q = 16'(-100 - ofdm_idx);

   frame_assembler_param #(
      .DW         (16),
      .PREAMB_LEN (PL),
      .SYM_LEN    (SL),
      .NSYM_W     (8),
      .GAP_LEN    (GL)
   ) dut (
      .i_clock    (clk),
      .i_reset    (reset),
      .i_enable   (enable),
      .i_ready_in (ready),
      .i_n_syms   (n_syms),
      .i_pre_i    (pre_i),
      .i_pre_q    (pre_q),
      .o_pre_req  (pre_req),
      .i_ofdm_i   (ofdm_i),
      .i_ofdm_q   (ofdm_q),
      .o_ofdm_req (ofdm_req),
      .o_i        (o_i),
      .o_q        (o_q),
      .o_sop      (sop),
      .o_eop      (eop),
      .o_sos      (sos),
      .o_busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
      end
   endtask

   function automatic ent_t zero_ent();
      ent_t e;
      e.i = '0; e.q = '0; e.sop = 1'b0; e.eop = 1'b0; e.sos = 1'b0; e.busy = 1'b0; e.src = 2'd0;
      return e;
   endfunction

   function automatic int flen(input int n);
`ifdef FRAME_GAP_EN
      return PL + SL * n + GL;
`else
      return PL + SL * n;
`endif
   endfunction

   task automatic push_zeros(input int cnt);
      for (int k = 0; k < cnt; k++) exp_q.push_back(zero_ent());
   endtask

   task automatic push_frame(input int n);
      ent_t e;
      for (int k = 0; k < PL; k++) begin
         e = zero_ent();
         e.i = 16'(10 + k); e.q = 16'(-(10 + k));
         e.sop = (k == 0); e.busy = 1'b1; e.src = 2'd1;
         exp_q.push_back(e);
      end
      for (int s = 0; s < n; s++) begin
         for (int t = 0; t < SL; t++) begin
            e = zero_ent();
            e.i = 16'(20 + exp_ofdm); e.q = 16'(-100 - exp_ofdm);
            exp_ofdm++;
            e.eop = (s == n - 1) && (t == SL - 1);
            e.sos = (t == 0);
`ifdef FRAME_GAP_EN
            e.busy = 1'b1;
`else
            e.busy = !e.eop;
`endif
            e.src = 2'd2;
            exp_q.push_back(e);
         end
      end
`ifdef FRAME_GAP_EN
      for (int g = 0; g < GL; g++) begin
         e = zero_ent();
         e.busy = (g != GL - 1);
         exp_q.push_back(e);
      end
`endif
   endtask

   // One clock: drive ready at negedge, check requests, then check registered outputs.
   task automatic cycle(input logic rdy);
      ent_t e;
      logic adv, pr, orq;
      e = zero_ent();
      @(negedge clk);
      ready = rdy;
      #1;
      adv = rdy & enable;
      pr  = pre_req;
      orq = ofdm_req;
      if (adv) begin
         if (exp_q.size() == 0) chk("q_underrun", 32'd1, 32'd0);
         else e = exp_q.pop_front();
         chk("pre_req", 32'(pr), 32'(e.src == 2'd1));
         chk("ofdm_req", 32'(orq), 32'(e.src == 2'd2));
      end else begin
         chk("pre_req_idle", 32'(pr), 32'd0);
         chk("ofdm_req_idle", 32'(orq), 32'd0);
      end
      @(posedge clk);
      #1;
      if (adv) begin
         chk("I", 32'(o_i), 32'(e.i));
         chk("Q", 32'(o_q), 32'(e.q));
         chk("sop", 32'(sop), 32'(e.sop));
         chk("eop", 32'(eop), 32'(e.eop));
         chk("sos", 32'(sos), 32'(e.sos));
         chk("busy", 32'(busy), 32'(e.busy));
         last = e;
      end else begin
         chk("I_hold", 32'(o_i), 32'(last.i));
         chk("Q_hold", 32'(o_q), 32'(last.q));
         chk("sop_idle", 32'(sop), 32'd0);
         chk("eop_idle", 32'(eop), 32'd0);
         chk("sos_idle", 32'(sos), 32'd0);
         chk("busy_idle", 32'(busy), 32'(last.busy));
      end
      if (pr) pre_idx++;
      if (orq) ofdm_idx++;
   endtask

   task automatic run_adv(input int cnt, input bit toggle);
      for (int k = 0; k < cnt; k++) begin
         cycle(1'b1);
         if (toggle) cycle(1'b0);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_I"}, 32'(o_i), 32'd0);
      chk({tag, "_Q"}, 32'(o_q), 32'd0);
      chk({tag, "_sop"}, 32'(sop), 32'd0);
      chk({tag, "_eop"}, 32'(eop), 32'd0);
      chk({tag, "_sos"}, 32'(sos), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      pre_idx = 0; ofdm_idx = 0; exp_ofdm = 0;
      last = zero_ent();
      reset = 1'b1; enable = 1'b1; ready = 1'b0; n_syms = 8'd0;
      repeat (2) @(negedge clk);
      #1 chk_all_zero("rst");
      @(negedge clk);
      reset = 1'b0;

      // 1: continuous requests, two symbols
      n_syms = 8'd2;
      push_frame(2);
      run_adv(flen(2), 1'b0);
      cycle(1'b0);
      cycle(1'b0);

      // 2: ready toggling, same frame shape
      push_frame(2);
      run_adv(flen(2), 1'b1);

      // 3: zero symbols -> idle zeros, then a one-symbol frame
      n_syms = 8'd0;
      push_zeros(50);
      run_adv(50, 1'b0);
      n_syms = 8'd1;
      push_frame(1);
      run_adv(flen(1), 1'b0);
      cycle(1'b0);

      // 4: reset on the 6th sample of a frame
      n_syms = 8'd2;
      push_frame(2);
      run_adv(6, 1'b0);
      @(negedge clk);
      ready = 1'b0;
      reset = 1'b1;
      #1 chk_all_zero("midrst");
      @(posedge clk);
      #1 chk_all_zero("midrst_edge");
      exp_q.delete();
      pre_idx = 0; ofdm_idx = 0; exp_ofdm = 0;
      last = zero_ent();
      @(negedge clk);
      reset = 1'b0;
      push_frame(2);
      run_adv(flen(2), 1'b0);
      cycle(1'b0);

      // 5: back-to-back frames, n_syms changed mid-frame
      n_syms = 8'd1;
      push_frame(1);
      push_frame(3);
      run_adv(2, 1'b0);
      n_syms = 8'd3;
      run_adv(flen(1) - 2 + flen(3), 1'b0);
      cycle(1'b0);

`ifdef FRAME_GAP_EN
      // 6: gap between two one-symbol frames
      n_syms = 8'd1;
      push_frame(1);
      push_frame(1);
      run_adv(2 * flen(1), 1'b0);
      cycle(1'b0);
`endif

      n_syms = 8'd0;
      cycle(1'b0);
      chk("q_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
